// File: rtl/dmem_responder.sv
// Single-port data-memory responder for the core's data port: fixed-latency reads,
// address error flagging and saturating read/write access counters.
module dmem_responder #(
  parameter int          ADDR_WIDTH = 10,
  parameter int          LATENCY    = 1,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_ram_ena,
  input  logic        data_ram_wea,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        addr_err,
  output logic        err_sticky,
  input  logic        err_clr,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count
);

  typedef struct packed {
    logic        rv;
    logic        er;
    logic [31:0] data;
  } rsp_t;

  logic [31:0]           mem [2**ADDR_WIDTH];
  logic [31:0]           off;
  logic [ADDR_WIDTH-1:0] idx;
  logic                  misaligned;
  logic                  out_of_range;
  logic                  err;
  logic                  good_rd;
  logic                  good_wr;
  rsp_t                  req_rsp;
  rsp_t                  tail_rsp;

  // BASE_ADDR is aligned to the memory size, so the low and high bits of the
  // offset give misalignment and range directly.
  assign off          = addr - BASE_ADDR;
  assign misaligned   = |off[1:0];
  assign out_of_range = |off[31:ADDR_WIDTH+2];
  assign err          = data_ram_ena & (misaligned | out_of_range);
  assign idx          = off[ADDR_WIDTH+1:2];
  assign good_wr      = data_ram_ena &  data_ram_wea & ~err;
  assign good_rd      = data_ram_ena & ~data_ram_wea & ~err;

  always_comb begin
    req_rsp.rv   = data_ram_ena & ~data_ram_wea;
    req_rsp.er   = err;
    req_rsp.data = good_rd ? mem[idx] : '0;
  end

  // NOTE: the array has no reset; contents must survive rst and a reset term
  // would stop it mapping onto RAM.
  always_ff @(posedge clk) begin
    if (good_wr) mem[idx] <= wdata;
  end

  generate
    if (LATENCY == 1) begin : g_direct
      assign tail_rsp = req_rsp;
    end else begin : g_pipe
      rsp_t pipe [LATENCY-1];

      // NOTE: non-blocking assignments let every stage shift on the same edge
      // regardless of statement order.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int i = 0; i < LATENCY-1; i++) pipe[i] <= '0;
        end else begin
          pipe[0] <= req_rsp;
          for (int i = 1; i < LATENCY-1; i++) pipe[i] <= pipe[i-1];
        end
      end

      assign tail_rsp = pipe[LATENCY-2];
    end
  endgenerate

  // rdata only moves on a response so it holds between pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata    <= '0;
      rvalid   <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      rvalid   <= tail_rsp.rv;
      addr_err <= tail_rsp.er;
      if (tail_rsp.rv) rdata <= tail_rsp.data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_sticky <= 1'b0;
      rd_count   <= '0;
      wr_count   <= '0;
    end else begin
      if (err)          err_sticky <= 1'b1;
      else if (err_clr) err_sticky <= 1'b0;
      if (good_rd && rd_count != '1) rd_count <= rd_count + 32'd1;
      if (good_wr && wr_count != '1) wr_count <= wr_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: four instances (LATENCY 1..4) share one stimulus stream and
// are compared every cycle against a history-based reference model plus directed vectors.
module tb_dmem_responder;

  localparam int NL = 4;

  logic        clk;
  logic        rst;
  logic        ena;
  logic        wea;
  logic        err_clr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata_a  [NL];
  logic        rvalid_a [NL];
  logic        aerr_a   [NL];
  logic        sticky_a [NL];
  logic [31:0] rd_a     [NL];
  logic [31:0] wr_a     [NL];

  dmem_responder #(.ADDR_WIDTH(10), .LATENCY(1), .BASE_ADDR(32'h0)) u_l1 (
    .clk(clk), .rst(rst), .data_ram_ena(ena), .data_ram_wea(wea), .addr(addr),
    .wdata(wdata), .rdata(rdata_a[0]), .rvalid(rvalid_a[0]), .addr_err(aerr_a[0]),
    .err_sticky(sticky_a[0]), .err_clr(err_clr), .rd_count(rd_a[0]), .wr_count(wr_a[0]));
  dmem_responder #(.ADDR_WIDTH(10), .LATENCY(2), .BASE_ADDR(32'h0)) u_l2 (
    .clk(clk), .rst(rst), .data_ram_ena(ena), .data_ram_wea(wea), .addr(addr),
    .wdata(wdata), .rdata(rdata_a[1]), .rvalid(rvalid_a[1]), .addr_err(aerr_a[1]),
    .err_sticky(sticky_a[1]), .err_clr(err_clr), .rd_count(rd_a[1]), .wr_count(wr_a[1]));
  dmem_responder #(.ADDR_WIDTH(10), .LATENCY(3), .BASE_ADDR(32'h0)) u_l3 (
    .clk(clk), .rst(rst), .data_ram_ena(ena), .data_ram_wea(wea), .addr(addr),
    .wdata(wdata), .rdata(rdata_a[2]), .rvalid(rvalid_a[2]), .addr_err(aerr_a[2]),
    .err_sticky(sticky_a[2]), .err_clr(err_clr), .rd_count(rd_a[2]), .wr_count(wr_a[2]));
  dmem_responder #(.ADDR_WIDTH(10), .LATENCY(4), .BASE_ADDR(32'h0)) u_l4 (
    .clk(clk), .rst(rst), .data_ram_ena(ena), .data_ram_wea(wea), .addr(addr),
    .wdata(wdata), .rdata(rdata_a[3]), .rvalid(rvalid_a[3]), .addr_err(aerr_a[3]),
    .err_sticky(sticky_a[3]), .err_clr(err_clr), .rd_count(rd_a[3]), .wr_count(wr_a[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: hist[k] is what the access made k edges ago should produce,
  // so a LATENCY=L instance shows hist[L-1] after each edge.
  typedef struct {
    bit        rv;
    bit        er;
    bit [31:0] d;
  } ent_t;

  bit [31:0] mem_m [1024];
  ent_t      hist [$];
  bit [31:0] last_rd [NL];
  bit [31:0] cnt_rd;
  bit [31:0] cnt_wr;
  bit        sticky_m;
  int        total;
  int        bad;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    ent_t z;
    z = '{rv: 1'b0, er: 1'b0, d: 32'h0};
    hist.delete();
    for (int i = 0; i < NL; i++) begin
      hist.push_back(z);
      last_rd[i] = 32'h0;
    end
    cnt_rd   = 32'h0;
    cnt_wr   = 32'h0;
    sticky_m = 1'b0;
  endtask

  task automatic model_step();
    ent_t      e;
    bit [31:0] off;
    bit        bad_acc;
    e   = '{rv: 1'b0, er: 1'b0, d: 32'h0};
    off = addr - 32'h0;
    if (rst) begin
      bad_acc = ena && ((off % 4) != 0 || off >= 32'd4096);
      e.rv    = ena && !wea;
      e.er    = bad_acc;
      if (e.rv && !bad_acc) e.d = mem_m[off / 4];
      if (ena && wea && !bad_acc) begin
        mem_m[off / 4] = wdata;
        cnt_wr = (cnt_wr == 32'hFFFF_FFFF) ? cnt_wr : cnt_wr + 1;
      end
      if (ena && !wea && !bad_acc)
        cnt_rd = (cnt_rd == 32'hFFFF_FFFF) ? cnt_rd : cnt_rd + 1;
      if (bad_acc)      sticky_m = 1'b1;
      else if (err_clr) sticky_m = 1'b0;
    end
    hist.push_front(e);
    while (hist.size() > NL) void'(hist.pop_back());
    for (int i = 0; i < NL; i++)
      if (hist[i].rv) last_rd[i] = hist[i].d;
  endtask

  task automatic compare_all();
    for (int i = 0; i < NL; i++) begin
      check($sformatf("L%0d rvalid", i+1),   32'(rvalid_a[i]), 32'(hist[i].rv));
      check($sformatf("L%0d addr_err", i+1), 32'(aerr_a[i]),   32'(hist[i].er));
      check($sformatf("L%0d rdata", i+1),    rdata_a[i],       last_rd[i]);
      check($sformatf("L%0d sticky", i+1),   32'(sticky_a[i]), 32'(sticky_m));
      check($sformatf("L%0d rd_count", i+1), rd_a[i],          cnt_rd);
      check($sformatf("L%0d wr_count", i+1), wr_a[i],          cnt_wr);
    end
  endtask

  // Called at a falling edge: drive, let the rising edge happen, then sample.
  task automatic cycle(input bit e, input bit w, input bit [31:0] a, input bit [31:0] d,
                       input bit clr);
    ena     = e;
    wea     = w;
    addr    = a;
    wdata   = d;
    err_clr = clr;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  typedef struct {
    bit        e, w, clr;
    bit [31:0] a, d;
    bit        rv, er;
    bit [31:0] rdata;
    bit        st;
    bit [31:0] rd, wr;
  } vec_t;

  vec_t      tbl [14];
  bit        seq_rv [6];
  bit [31:0] seq_rd [6];
  bit [31:0] a_r;
  int        kind;

  initial begin
    total = 0;
    bad   = 0;
    ena = 1'b0; wea = 1'b0; addr = 32'h0; wdata = 32'h0; err_clr = 1'b0;
    rst = 1'b1;
    model_reset();
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    compare_all();
    rst = 1'b1;

    // Expected values below are for the LATENCY=1 instance after each vector's edge.
    //           e  w clr  addr           wdata         rv er rdata          st rd wr
    tbl[0]  = '{1, 1, 0, 32'h0000_0010, 32'hDEAD_BEEF, 0, 0, 32'h0,         0, 0, 1};
    tbl[1]  = '{1, 0, 0, 32'h0000_0010, 32'h0,         1, 0, 32'hDEAD_BEEF, 0, 1, 1};
    tbl[2]  = '{0, 0, 0, 32'h0000_0000, 32'h0,         0, 0, 32'hDEAD_BEEF, 0, 1, 1};
    tbl[3]  = '{1, 1, 0, 32'h0000_0000, 32'h1111_0000, 0, 0, 32'hDEAD_BEEF, 0, 1, 2};
    tbl[4]  = '{1, 0, 0, 32'h0000_0013, 32'h0,         1, 1, 32'h0,         1, 1, 2};
    tbl[5]  = '{1, 1, 0, 32'h0000_1000, 32'h0000_0BAD, 0, 1, 32'h0,         1, 1, 2};
    tbl[6]  = '{1, 0, 0, 32'h0000_0000, 32'h0,         1, 0, 32'h1111_0000, 1, 2, 2};
    tbl[7]  = '{0, 0, 1, 32'h0000_0000, 32'h0,         0, 0, 32'h1111_0000, 0, 2, 2};
    tbl[8]  = '{1, 0, 1, 32'hFFFF_FFFC, 32'h0,         1, 1, 32'h0,         1, 2, 2};
    tbl[9]  = '{1, 1, 0, 32'h0000_0020, 32'h0000_0055, 0, 0, 32'h0,         1, 2, 3};
    tbl[10] = '{1, 0, 0, 32'h0000_0020, 32'h0,         1, 0, 32'h0000_0055, 1, 3, 3};
    tbl[11] = '{1, 1, 0, 32'h0000_0020, 32'h0000_00AA, 0, 0, 32'h0000_0055, 1, 3, 4};
    tbl[12] = '{1, 0, 0, 32'h0000_0020, 32'h0,         1, 0, 32'h0000_00AA, 1, 4, 4};
    tbl[13] = '{0, 1, 0, 32'h0000_0013, 32'h0,         0, 0, 32'h0000_00AA, 1, 4, 4};

    for (int i = 0; i < 14; i++) begin
      cycle(tbl[i].e, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].clr);
      check($sformatf("tbl%0d rvalid", i),   32'(rvalid_a[0]), 32'(tbl[i].rv));
      check($sformatf("tbl%0d addr_err", i), 32'(aerr_a[0]),   32'(tbl[i].er));
      check($sformatf("tbl%0d rdata", i),    rdata_a[0],       tbl[i].rdata);
      check($sformatf("tbl%0d sticky", i),   32'(sticky_a[0]), 32'(tbl[i].st));
      check($sformatf("tbl%0d rd_count", i), rd_a[0],          tbl[i].rd);
      check($sformatf("tbl%0d wr_count", i), wr_a[0],          tbl[i].wr);
    end

    // Back-to-back reads seen through the LATENCY=3 instance.
    cycle(1, 1, 32'h0, 32'h1, 0);
    cycle(1, 1, 32'h4, 32'h2, 0);
    cycle(1, 1, 32'h8, 32'h3, 0);
    for (int k = 0; k < 6; k++) begin
      if (k < 3) cycle(1, 0, 32'(k * 4), 32'h0, 0);
      else       cycle(0, 0, 32'h0, 32'h0, 0);
      seq_rv[k] = rvalid_a[2];
      seq_rd[k] = rdata_a[2];
    end
    check("l3 seq rvalid0", 32'(seq_rv[0]), 32'h0);
    check("l3 seq rvalid1", 32'(seq_rv[1]), 32'h0);
    check("l3 seq rvalid2", 32'(seq_rv[2]), 32'h1);
    check("l3 seq rvalid3", 32'(seq_rv[3]), 32'h1);
    check("l3 seq rvalid4", 32'(seq_rv[4]), 32'h1);
    check("l3 seq rvalid5", 32'(seq_rv[5]), 32'h0);
    check("l3 seq rdata2",  seq_rd[2], 32'h1);
    check("l3 seq rdata3",  seq_rd[3], 32'h2);
    check("l3 seq rdata4",  seq_rd[4], 32'h3);

    // Reset asserted mid-cycle while reads are still in flight in the deeper instances.
    cycle(1, 0, 32'h20, 32'h0, 0);
    #2 rst = 1'b0;
    #1;
    model_reset();
    compare_all();
    check("rst l2 rdata",  rdata_a[1], 32'h0);
    check("rst l2 rvalid", 32'(rvalid_a[1]), 32'h0);
    cycle(0, 0, 32'h0, 32'h0, 0);
    cycle(0, 0, 32'h0, 32'h0, 0);
    rst = 1'b1;
    for (int k = 0; k < 5; k++) cycle(0, 0, 32'h0, 32'h0, 0);
    cycle(1, 0, 32'h20, 32'h0, 0);
    check("rst mem kept", rdata_a[0], 32'hAA);
    for (int k = 0; k < 4; k++) cycle(0, 0, 32'h0, 32'h0, 0);

    // Fill the words the random phase reads, including the last word of the array.
    for (int wi = 0; wi < 64; wi++) cycle(1, 1, 32'(wi * 4), $urandom, 0);
    cycle(1, 1, 32'hFFC, $urandom, 0);

    for (int n = 0; n < 400; n++) begin
      kind = $urandom_range(0, 9);
      case (kind)
        0:       a_r = 32'($urandom_range(0, 63) * 4 + $urandom_range(1, 3));
        1:       a_r = 32'h1000 + 32'($urandom_range(0, 255) * 4);
        2:       a_r = 32'hFFC;
        3:       a_r = 32'hFFFF_FF00 + 32'($urandom_range(0, 63) * 4);
        default: a_r = 32'($urandom_range(0, 63) * 4);
      endcase
      cycle($urandom_range(0, 99) < 80, 1'($urandom_range(0, 1)), a_r, $urandom,
            $urandom_range(0, 9) == 0);
    end
    for (int k = 0; k < 4; k++) cycle(0, 0, 32'h0, 32'h0, 0);

    // Saturation: preload the write counters one below the ceiling.
    force u_l1.wr_count = 32'hFFFF_FFFE;
    force u_l2.wr_count = 32'hFFFF_FFFE;
    force u_l3.wr_count = 32'hFFFF_FFFE;
    force u_l4.wr_count = 32'hFFFF_FFFE;
    #1;
    release u_l1.wr_count;
    release u_l2.wr_count;
    release u_l3.wr_count;
    release u_l4.wr_count;
    cnt_wr = 32'hFFFF_FFFE;
    cycle(1, 1, 32'h40, 32'h1234_5678, 0);
    check("sat wr 1", wr_a[0], 32'hFFFF_FFFF);
    cycle(1, 1, 32'h44, 32'h9ABC_DEF0, 0);
    cycle(1, 1, 32'h48, 32'h0F0F_0F0F, 0);
    check("sat wr 3", wr_a[0], 32'hFFFF_FFFF);
    check("sat wr 3 l4", wr_a[3], 32'hFFFF_FFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
